// File: rtl/ysyx22040413_lsu_if.sv
// Request/response and data-memory signals of the LSU. The LSU takes the
// slave view; the EXU side and the memory together take the master view.
interface ysyx22040413_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx22040413_lsu.sv
// Load/store unit: one multi-cycle access per request on a 64-bit memory port,
// with lane formatting for stores and alignment/extension for loads.
module ysyx22040413_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx22040413_lsu_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [15:0] TO_L = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        timeout;
  logic        accept;
  logic        misalign;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  off_q;
  logic [63:0] raw;
  logic [63:0] mem_addr_q;
  logic        mem_wen_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_wmask_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] r, input logic [1:0] size,
                                           input logic uns);
    logic signed [63:0] ext;
    case (size)
      2'd0:    ext = uns ? {56'd0, r[7:0]}  : {{56{r[7]}},  r[7:0]};
      2'd1:    ext = uns ? {48'd0, r[15:0]} : {{48{r[15]}}, r[15:0]};
      2'd2:    ext = uns ? {32'd0, r[31:0]} : {{32{r[31]}}, r[31:0]};
      default: ext = r;
    endcase
    return ext;
  endfunction

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      2'd3:    misalign = |bus.req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  // >= rather than == so a WAIT entered after a REQ that already hit the limit still expires
  assign cnt_inc = cnt + 16'd1;
  assign timeout = (cnt_inc >= TO_L);
  assign raw     = bus.mem_rdata >> {off_q, 3'b000};

  // completion events take priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = misalign ? RESP : REQ;
      REQ: begin
        if (bus.mem_ready)  state_nxt = mem_wen_q ? RESP : WAIT;
        else if (timeout)   state_nxt = RESP;
      end
      WAIT: if (bus.mem_rvalid || timeout) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE)        cnt <= 16'd0;
    else if (state == REQ || state == WAIT) cnt <= cnt_inc;
  end

  // ---- accept stage: latch request and pre-format the memory beat ----
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q <= bus.req_size;
      uns_q  <= bus.req_unsigned;
      off_q  <= bus.req_addr[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= 64'd0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 64'd0;
      mem_wmask_q <= 8'd0;
    end else if (accept) begin
      mem_addr_q  <= {bus.req_addr[63:3], 3'b000};
      mem_wen_q   <= bus.req_wen;
      mem_wdata_q <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
      mem_wmask_q <= bus.req_wen ? lane_mask(bus.req_size, bus.req_addr[2:0]) : 8'h00;
    end
  end

  // ---- response stage: result registered on entry to RESP ----
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && misalign) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 64'd0;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            if (mem_wen_q) begin
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 64'd0;
            end
          end else if (timeout) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 64'd0;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_ext(raw, size_q, uns_q);
          end else if (timeout) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 64'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_valid  = (state == REQ);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;

endmodule

// File: doc/ysyx22040413_lsu.md
Name: ysyx22040413_lsu

Overview:
- Load/store unit directly downstream of the EXU in the ysyx22040413 core.
- Takes the effective address and store data the EXU produces, plus the access size and sign mode from decode.
- Runs one multi-cycle access on a 64-bit data-memory port using a valid/ready request and an rvalid response.
- Returns load data, already aligned and extended, for regfile write-back; the core stalls until resp_valid.

Parameters:
TIMEOUT, 255, number of cycles spent in REQ+WAIT before the access is aborted with an error (legal range 1..65535)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  EXU presents a memory access
req_ready  output  1  LSU can accept a request
req_wen  input  1  1 = store, 0 = load
req_addr  input  64  byte address from EXU
req_wdata  input  64  store data, LSB-aligned
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  64  extended load data; 0 for stores and errors
resp_err  output  1  misaligned access or timeout; valid with resp_valid
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_addr  output  64  req_addr with bits [2:0] cleared
mem_wen  output  1  store strobe
mem_wdata  output  64  store data shifted into byte lanes
mem_wmask  output  8  byte-lane enables
mem_rvalid  input  1  load data valid
mem_rdata  input  64  raw 64-bit memory word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- On reset: state IDLE, timeout counter 0, and these outputs are 0: resp_valid, resp_err, resp_rdata, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask. req_ready is 1 in the first cycle after reset.
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready is 1 exactly when the state is IDLE.
- Acceptance: a request is accepted when req_valid && req_ready. At that edge all request fields are latched; later input changes are ignored.
- Misalignment check, made at acceptance:
  - half: addr[0] != 0 is misaligned.
  - word: addr[1:0] != 0 is misaligned.
  - double: addr[2:0] != 0 is misaligned.
  - A misaligned request goes IDLE -> RESP with resp_err = 1 and resp_rdata = 0. mem_valid is never raised.
- An aligned request goes IDLE -> REQ.
- REQ state:
  - mem_valid = 1 and mem_addr, mem_wen, mem_wdata, mem_wmask stay stable until mem_ready.
  - On mem_valid && mem_ready: a store goes to RESP; a load goes to WAIT.
- Store lane formatting:
  - mem_wdata = wdata << (8 × addr[2:0]).
  - mem_wmask = ((1 << 2^size) − 1) << addr[2:0]. Examples: byte at offset 5 -> 0x20; word at offset 4 -> 0xF0.
  - For loads, mem_wmask = 0.
- WAIT state:
  - mem_valid = 0.
  - On mem_rvalid, raw = mem_rdata >> (8 × addr[2:0]).
  - The low 8/16/32/64 bits of raw are zero- or sign-extended per req_unsigned and registered into resp_rdata. The state goes to RESP.
  - A mem_rvalid arriving in the same cycle as the REQ handshake is ignored; the earliest load data is taken one cycle after the handshake.
- RESP state: resp_valid = 1 for exactly one cycle, then IDLE. req_ready is 0 during RESP, so back-to-back requests are separated by at least one cycle.
- Latency from accept edge T, with zero-wait memory:
  - Store: mem_valid during T+1, resp_valid during T+2.
  - Load with mem_rvalid at T+2: resp_valid during T+3.
  - Misaligned: resp_valid during T+1.
- Timeout: the counter increments in every REQ or WAIT cycle and clears on entry to IDLE. On the cycle it reaches TIMEOUT, the state goes to RESP with resp_err = 1 and resp_rdata = 0, and mem_valid drops.
- Simultaneous events: a completion event (mem_ready in REQ, or mem_rvalid in WAIT) in the same cycle as the timeout takes priority, and resp_err = 0.
- mem_rvalid or mem_ready seen in IDLE or RESP is ignored.
- Reset mid-operation: rst in any state returns to IDLE within the same edge. The access is dropped, no resp_valid is produced, and a late mem_rvalid after reset is ignored.
- resp_err and resp_rdata hold their value until the next RESP entry. They are only meaningful while resp_valid = 1.

Test Plan:
- Load double, addr 0x80000008, mem_ready immediate, mem_rvalid one cycle later with mem_rdata 0x1122334455667788 -> mem_addr 0x80000008, wmask 0x00, resp_valid 3 cycles after accept, resp_rdata 0x1122334455667788, resp_err 0.
- Load byte signed at 0x80000003, mem_rdata 0x00000000_80FF0000 -> resp_rdata 0xFFFFFFFFFFFFFF80. The same access with req_unsigned = 1 -> 0x0000000000000080.
- Store half 0xABCD at 0x80000006 -> mem_addr 0x80000000, mem_wdata 0xABCD000000000000, mem_wmask 0xC0, mem_wen 1, resp_valid 2 cycles after accept, resp_err 0.
- Store word at 0x80000002 -> no mem_valid ever, resp_valid next cycle with resp_err 1. req_ready is back to 1 one cycle later.
- Load with TIMEOUT = 4 and mem_ready held low -> mem_valid high for 4 cycles, then resp_valid with resp_err 1 and resp_rdata 0. A later stray mem_rvalid produces no response.
- Load accepted, mem handshake done, rst asserted in WAIT -> the next cycle is IDLE with all outputs at reset values. A following mem_rvalid is ignored, and a new request is accepted normally.
